// File: rtl/plab2_proc_bypass_scoreboard_pkg.sv
// Shared definitions for plab2_proc_bypass_scoreboard: RF select encoding,
// packed entry layout helpers and the result-ready stage clamp.
package plab2_proc_bypass_scoreboard_pkg;

  localparam int unsigned RF_SEL = 0;

  // Entry layout, MSB to LSB: {val, wen, waddr[aw], rdy_stage[sw]}
  function automatic int unsigned entry_w(input int unsigned aw, input int unsigned sw);
    return aw + sw + 2;
  endfunction

  function automatic int unsigned waddr_lsb(input int unsigned sw);
    return sw;
  endfunction

  function automatic int unsigned wen_bit(input int unsigned aw, input int unsigned sw);
    return sw + aw;
  endfunction

  function automatic int unsigned val_bit(input int unsigned aw, input int unsigned sw);
    return sw + aw + 1;
  endfunction

  function automatic int unsigned clamp_stage(input int unsigned s, input int unsigned n);
    if (s == 0) return 1;
    if (s > n)  return n;
    return s;
  endfunction

endpackage

// File: rtl/plab2_proc_bypass_scoreboard_lookup.sv
// Per-read-port priority search over the in-flight entries: youngest matching
// writer decides between a bypass select and a stall request.
module plab2_proc_bypass_scoreboard_lookup
  import plab2_proc_bypass_scoreboard_pkg::*;
#(
  parameter  int unsigned p_nstages = 3,
  parameter  int unsigned c_aw      = 5,
  parameter  int unsigned c_sw      = 2,
  localparam int unsigned c_ew      = entry_w(c_aw, c_sw)
)(
  input  logic [p_nstages*c_ew-1:0] entries_i,
  input  logic [c_aw-1:0]           raddr_i,
  input  logic                      rval_i,
  output logic [c_sw-1:0]           sel_o,
  output logic                      stall_o
);

  localparam int unsigned c_wl = waddr_lsb(c_sw);
  localparam int unsigned c_wb = wen_bit(c_aw, c_sw);
  localparam int unsigned c_vb = val_bit(c_aw, c_sw);

  logic            hit;
  logic [c_sw-1:0] win_k;
  logic [c_sw-1:0] win_rdy;
  logic [c_ew-1:0] e;

  // Stage 1 is searched first; the first hit is the youngest and locks out older ones.
  always_comb begin
    hit     = 1'b0;
    win_k   = '0;
    win_rdy = '0;
    e       = '0;
    for (int unsigned k = 0; k < p_nstages; k++) begin
      e = entries_i[k*c_ew +: c_ew];
      if (!hit && e[c_vb] && e[c_wb] && (e[c_wl +: c_aw] == raddr_i) && (raddr_i != '0)) begin
        hit     = 1'b1;
        win_k   = c_sw'(k + 1);
        win_rdy = e[c_sw-1:0];
      end
    end
  end

  always_comb begin
    sel_o   = c_sw'(RF_SEL);
    stall_o = 1'b0;
    if (hit && rval_i) begin
      if (win_k >= win_rdy) sel_o   = win_k;
      else                  stall_o = 1'b1;
    end
  end

endmodule

// File: rtl/plab2_proc_bypass_scoreboard.sv
// Destination-register scoreboard for the post-D pipeline stages, driving bypass
// selects, the D-stage RAW stall and the W-stage RF write. Optional activity
// counters are enabled by PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN.
module plab2_proc_bypass_scoreboard
  import plab2_proc_bypass_scoreboard_pkg::*;
#(
  parameter  int unsigned p_nstages = 3,
  parameter  int unsigned p_nrports = 2,
  parameter  int unsigned p_nregs   = 32,
  localparam int unsigned c_aw      = $clog2(p_nregs),
  localparam int unsigned c_sw      = $clog2(p_nstages + 1)
)(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [p_nrports*c_aw-1:0]   raddr_D,
  input  logic [p_nrports-1:0]        rval_D,
  input  logic                        issue_go_D,
  input  logic                        issue_wen_D,
  input  logic [c_aw-1:0]             issue_waddr_D,
  input  logic [c_sw-1:0]             issue_rdy_stage_D,
  input  logic [p_nstages-1:0]        stage_en,
  output logic [p_nrports*c_sw-1:0]   byp_sel_D,
  output logic                        stall_D,
  output logic                        rf_wen_W,
  output logic [c_aw-1:0]             rf_waddr_W
`ifdef PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 byp_cycles
`endif
);

  localparam int unsigned c_ew = entry_w(c_aw, c_sw);

  logic [p_nstages-1:0]           val_q, val_d;
  logic [p_nstages-1:0]           wen_q, wen_d;
  logic [p_nstages-1:0][c_aw-1:0] waddr_q, waddr_d;
  logic [p_nstages-1:0][c_sw-1:0] rdy_q, rdy_d;

  logic [c_sw-1:0]                issue_rdy;
  logic [p_nstages*c_ew-1:0]      entries;
  logic [p_nrports-1:0]           stall_req;

  assign issue_rdy = c_sw'(clamp_stage(32'(issue_rdy_stage_D), p_nstages));

  // A stage whose predecessor is frozen takes a bubble rather than a duplicate.
  always_comb begin
    val_d   = val_q;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    rdy_d   = rdy_q;
    if (stage_en[0]) begin
      val_d[0]   = issue_go_D;
      wen_d[0]   = issue_wen_D;
      waddr_d[0] = issue_waddr_D;
      rdy_d[0]   = issue_rdy;
    end
    for (int unsigned j = 1; j < p_nstages; j++) begin
      if (stage_en[j]) begin
        val_d[j]   = stage_en[j-1] & val_q[j-1];
        wen_d[j]   = wen_q[j-1];
        waddr_d[j] = waddr_q[j-1];
        rdy_d[j]   = rdy_q[j-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q   <= '0;
      wen_q   <= '0;
      waddr_q <= '0;
      rdy_q   <= '0;
    end else begin
      val_q   <= val_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    entries = '0;
    for (int unsigned j = 0; j < p_nstages; j++) begin
      entries[j*c_ew +: c_ew] = {val_q[j], wen_q[j], waddr_q[j], rdy_q[j]};
    end
  end

  for (genvar i = 0; i < p_nrports; i++) begin : g_port
    plab2_proc_bypass_scoreboard_lookup #(
      .p_nstages (p_nstages),
      .c_aw      (c_aw),
      .c_sw      (c_sw)
    ) u_lookup (
      .entries_i (entries),
      .raddr_i   (raddr_D[i*c_aw +: c_aw]),
      .rval_i    (rval_D[i]),
      .sel_o     (byp_sel_D[i*c_sw +: c_sw]),
      .stall_o   (stall_req[i])
    );
  end

  assign stall_D    = |stall_req;
  assign rf_wen_W   = val_q[p_nstages-1] & wen_q[p_nstages-1];
  assign rf_waddr_W = waddr_q[p_nstages-1];

`ifdef PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] byp_cycles_q, byp_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, stall_D};
    byp_cycles_d   = byp_cycles_q + {31'd0, (|byp_sel_D) & ~stall_D};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      byp_cycles_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      byp_cycles_q   <= byp_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign byp_cycles   = byp_cycles_q;
`endif

  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (reset) !(issue_go_D && stall_D));

endmodule

// File: tb/tb_plab2_proc_bypass_scoreboard.sv
// Directed scoreboard bench for plab2_proc_bypass_scoreboard (default 3 stages,
// 2 read ports, 32 registers); expectations are queued at drive time.
module tb_plab2_proc_bypass_scoreboard;

  logic        clk;
  logic        reset;
  logic [9:0]  raddr_D;
  logic [1:0]  rval_D;
  logic        issue_go_D;
  logic        issue_wen_D;
  logic [4:0]  issue_waddr_D;
  logic [1:0]  issue_rdy_stage_D;
  logic [2:0]  stage_en;
  logic [3:0]  byp_sel_D;
  logic        stall_D;
  logic        rf_wen_W;
  logic [4:0]  rf_waddr_W;
`ifdef PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] byp_cycles;
`endif

  plab2_proc_bypass_scoreboard #(
    .p_nstages (3),
    .p_nrports (2),
    .p_nregs   (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .raddr_D           (raddr_D),
    .rval_D            (rval_D),
    .issue_go_D        (issue_go_D),
    .issue_wen_D       (issue_wen_D),
    .issue_waddr_D     (issue_waddr_D),
    .issue_rdy_stage_D (issue_rdy_stage_D),
    .stage_en          (stage_en),
    .byp_sel_D         (byp_sel_D),
    .stall_D           (stall_D),
    .rf_wen_W          (rf_wen_W),
    .rf_waddr_W        (rf_waddr_W)
`ifdef PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN
    ,
    .stall_cycles      (stall_cycles),
    .byp_cycles        (byp_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       stall;
    logic       rfw;
    logic [4:0] rfa;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = q.pop_front();
      cmp({e.tag, ".sel0"},  32'(byp_sel_D[1:0]), 32'(e.sel0));
      cmp({e.tag, ".sel1"},  32'(byp_sel_D[3:2]), 32'(e.sel1));
      cmp({e.tag, ".stall"}, 32'(stall_D),        32'(e.stall));
      cmp({e.tag, ".rfw"},   32'(rf_wen_W),       32'(e.rfw));
      if (e.rfw) cmp({e.tag, ".rfa"}, 32'(rf_waddr_W), 32'(e.rfa));
    end
  endtask

  // One cycle: drive just after the edge, queue expectation, sample mid-cycle.
  task automatic step(input string tag,
                      input logic go, input logic [4:0] wa, input logic [1:0] rdy,
                      input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] rv,
                      input logic [2:0] en,
                      input logic [1:0] s0, input logic [1:0] s1, input logic st,
                      input logic rfw, input logic [4:0] rfa);
    exp_t e;
    @(posedge clk);
    #1;
    issue_go_D        = go;
    issue_wen_D       = 1'b1;
    issue_waddr_D     = wa;
    issue_rdy_stage_D = rdy;
    raddr_D           = {ra1, ra0};
    rval_D            = rv;
    stage_en          = en;
    e.tag = tag; e.sel0 = s0; e.sel1 = s1; e.stall = st; e.rfw = rfw; e.rfa = rfa;
    q.push_back(e);
    #2;
    check_outputs();
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    raddr_D = '0; rval_D = '0; issue_go_D = 1'b0; issue_wen_D = 1'b0;
    issue_waddr_D = '0; issue_rdy_stage_D = '0; stage_en = 3'b111;
    #2;
    e.tag = "reset"; e.sel0 = 2'd0; e.sel1 = 2'd0; e.stall = 1'b0; e.rfw = 1'b0; e.rfa = 5'd0;
    q.push_back(e);
    check_outputs();
`ifdef PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN
    cmp("reset.stall_cycles", stall_cycles, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    //   tag       go wa  rdy ra0 ra1 rv     en      s0 s1 st rfw rfa
    step("alu_iss",  1, 3,  1,  3,  0, 2'b11, 3'b111, 0, 0, 0, 0, 0);
    step("alu_x",    0, 0,  1,  3,  0, 2'b11, 3'b111, 1, 0, 0, 0, 0);
    step("alu_m",    0, 0,  1,  3,  0, 2'b11, 3'b111, 2, 0, 0, 0, 0);
    step("alu_w",    0, 0,  1,  3,  0, 2'b11, 3'b111, 3, 0, 0, 1, 3);
    step("alu_rf",   0, 0,  1,  3,  0, 2'b11, 3'b111, 0, 0, 0, 0, 0);
    step("ld_iss",   1, 5,  2,  0,  5, 2'b11, 3'b111, 0, 0, 0, 0, 0);
    step("ld_use",   0, 0,  1,  0,  5, 2'b11, 3'b111, 0, 0, 1, 0, 0);
    step("ld_m",     0, 0,  1,  0,  5, 2'b11, 3'b111, 0, 2, 0, 0, 0);
    step("ld_w",     1, 7,  1,  0,  5, 2'b11, 3'b111, 0, 3, 0, 1, 5);
    step("r7a_x",    0, 0,  1,  7,  0, 2'b11, 3'b111, 1, 0, 0, 0, 0);
    step("r7b_iss",  1, 7,  2,  7,  0, 2'b11, 3'b111, 2, 0, 0, 0, 0);
    step("youngest", 0, 0,  1,  7,  0, 2'b11, 3'b111, 0, 0, 1, 1, 7);
    step("r0_iss",   1, 0,  1,  0,  0, 2'b11, 3'b111, 0, 0, 0, 0, 0);
    step("r0_read",  1, 3,  1,  0,  0, 2'b11, 3'b111, 0, 0, 0, 1, 7);
    step("rval_off", 0, 0,  1,  3,  3, 2'b10, 3'b111, 0, 1, 0, 0, 0);
    step("r0_w",     1, 11, 1,  0,  0, 2'b11, 3'b111, 0, 0, 0, 1, 0);
    step("fill_b",   1, 12, 1,  0,  0, 2'b11, 3'b111, 0, 0, 0, 1, 3);
    step("fill_c",   1, 13, 1,  0,  0, 2'b11, 3'b111, 0, 0, 0, 0, 0);
    step("en110",    0, 0,  1, 13, 12, 2'b11, 3'b110, 1, 2, 0, 1, 11);
    step("bubble",   0, 0,  1, 13, 12, 2'b11, 3'b111, 1, 3, 0, 1, 12);
    step("post_b",   0, 0,  1, 13, 12, 2'b11, 3'b111, 2, 0, 0, 0, 0);
    step("w13",      0, 0,  1, 13,  0, 2'b11, 3'b000, 3, 0, 0, 1, 13);
    step("w13_hold", 1, 20, 0, 13,  0, 2'b11, 3'b111, 3, 0, 0, 1, 13);
    step("clamp0",   1, 21, 1, 20,  0, 2'b11, 3'b111, 1, 0, 0, 0, 0);
    step("fill3",    1, 22, 1, 20,  0, 2'b11, 3'b111, 2, 0, 0, 0, 0);
    step("full",     0, 0,  1, 22, 20, 2'b11, 3'b111, 1, 3, 0, 1, 20);

    #1;
    reset = 1'b1;
    #1;
    e.tag = "mid_reset"; e.sel0 = 2'd0; e.sel1 = 2'd0; e.stall = 1'b0; e.rfw = 1'b0; e.rfa = 5'd0;
    q.push_back(e);
    check_outputs();
`ifdef PLAB2_PROC_BYPASS_SCOREBOARD_STATS_EN
    cmp("mid_reset.stall_cycles", stall_cycles, 32'd0);
    cmp("mid_reset.byp_cycles", byp_cycles, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step("after_rst", 0, 0, 1, 22, 20, 2'b11, 3'b111, 0, 0, 0, 0, 0);

    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
